// File: rtl/variable_table_writer_if.sv
// -----------------------------------------------------------------------------
// variable_table_writer_if
// Bundles the control and table-side signals of variable_table_writer.
//
// Signals:
//   init_start / init_seed   : request a random initialisation sweep + LFSR seed
//   init_busy / init_done    : sweep in progress / one-cycle completion pulse
//   flip_valid / flip_ready  : single-variable write request handshake
//   flip_addr / flip_value   : variable index and new value
//   flip_drop                : one-cycle pulse when an accepted flip is out of range
//   en_b / we_b / addr_b / din_b : broadcast port-B write bus to every table
//
// Handshake: a flip transfers on a rising edge where flip_valid && flip_ready
// are both high; flip_valid/addr/value must be stable while waiting for
// ready, and flip_ready never depends on flip_valid.
//
// Modports: master drives requests (bench / upstream logic), slave is the writer.
// -----------------------------------------------------------------------------
interface variable_table_writer_if #(
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int CLUSTER_SIZE           = 40
);
    logic                                           init_start;
    logic [15:0]                                    init_seed;
    logic                                           init_busy;
    logic                                           init_done;
    logic                                           flip_valid;
    logic                                           flip_ready;
    logic [VARIABLE_ADDRESS_WIDTH-1:0]              flip_addr;
    logic                                           flip_value;
    logic                                           flip_drop;
    logic [CLUSTER_SIZE-1:0]                        en_b;
    logic [CLUSTER_SIZE-1:0]                        we_b;
    logic [VARIABLE_ADDRESS_WIDTH*CLUSTER_SIZE-1:0] addr_b;
    logic [CLUSTER_SIZE-1:0]                        din_b;

    modport master (
        output init_start, init_seed, flip_valid, flip_addr, flip_value,
        input  init_busy, init_done, flip_ready, flip_drop,
        input  en_b, we_b, addr_b, din_b
    );

    modport slave (
        input  init_start, init_seed, flip_valid, flip_addr, flip_value,
        output init_busy, init_done, flip_ready, flip_drop,
        output en_b, we_b, addr_b, din_b
    );
endinterface

// File: rtl/variable_table_writer.sv
// -----------------------------------------------------------------------------
// variable_table_writer
// Writes variable values into CLUSTER_SIZE identical variable tables through
// their port B. Two sources of writes:
//   * single flips (flip handshake), one per cycle, out-of-range ones dropped
//   * an init sweep writing LFSR-generated bits to every address 0..N-1
// All tables receive the same write (broadcast).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   bus          : variable_table_writer_if slave (control + table bus)
//   dbg_state_o  : current FSM state, 1 = INIT sweep, 0 = IDLE
// -----------------------------------------------------------------------------
module variable_table_writer #(
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int CLUSTER_SIZE           = 40,
    parameter int NUM_VARIABLES          = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    variable_table_writer_if.slave  bus,
    output logic                    dbg_state_o
);
    localparam int              W            = VARIABLE_ADDRESS_WIDTH;
    localparam logic [15:0]     DEFAULT_SEED = 16'hACE1;
    localparam logic [W-1:0]    LAST_ADDR    = W'(NUM_VARIABLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [W-1:0]   addr_q, addr_d;
    logic           din_q, din_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           drop_q, drop_d;

    logic           flip_ready;
    logic           flip_in_range;
    logic [15:0]    seed_eff;

    // Fibonacci LFSR, taps 16,14,13,11: feedback enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is substituted.
    assign seed_eff      = (bus.init_seed == 16'h0000) ? DEFAULT_SEED : bus.init_seed;
    assign flip_in_range = (32'(bus.flip_addr) < 32'(NUM_VARIABLES));
    assign flip_ready    = (state_q == IDLE) && !bus.init_start;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = '0;
        din_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.init_start) begin
                    // The write for address 0 is issued on the accepting edge,
                    // so the INIT state lines up exactly with the write cycles.
                    // The register then holds the LFSR one step ahead, ready
                    // for the write to address 1.
                    state_d = INIT;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    din_d   = seed_eff[0];
                    lfsr_d  = lfsr_step(seed_eff);
                    busy_d  = 1'b1;
                end else if (bus.flip_valid && flip_ready) begin
                    if (flip_in_range) begin
                        wr_d   = 1'b1;
                        addr_d = bus.flip_addr;
                        din_d  = bus.flip_value;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            INIT: begin
                // cnt_q is the address being written in this cycle.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wr_d   = 1'b1;
                    addr_d = cnt_q + 1'b1;
                    din_d  = lfsr_q[0];
                    lfsr_d = lfsr_step(lfsr_q);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.flip_ready = flip_ready;
    assign bus.init_busy  = busy_q;
    assign bus.init_done  = done_q;
    assign bus.flip_drop  = drop_q;
    assign bus.en_b       = {CLUSTER_SIZE{wr_q}};
    assign bus.we_b       = {CLUSTER_SIZE{wr_q}};
    assign bus.addr_b     = {CLUSTER_SIZE{addr_q}};
    assign bus.din_b      = {CLUSTER_SIZE{din_q}};
    assign dbg_state_o    = (state_q == INIT);
endmodule

// File: tb/tb_variable_table_writer.sv
// -----------------------------------------------------------------------------
// tb_variable_table_writer
// Bench for variable_table_writer with a small configuration (4-bit addresses,
// 5 tables, 8 variables). A reference model turns every accepted request into
// the list of per-cycle bus values it must produce; those go into an expected
// queue that is consumed one entry per clock and compared with the DUT.
// -----------------------------------------------------------------------------
module tb_variable_table_writer;
    localparam int W = 4;
    localparam int C = 5;
    localparam int N = 8;

    typedef struct packed {
        logic         wr;
        logic [W-1:0] addr;
        logic         din;
        logic         busy;
        logic         done;
        logic         drop;
    } exp_t;

    logic clk;
    logic rst;
    logic dbg_state;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    variable_table_writer_if #(
        .VARIABLE_ADDRESS_WIDTH(W),
        .CLUSTER_SIZE(C)
    ) bus ();

    variable_table_writer #(
        .VARIABLE_ADDRESS_WIDTH(W),
        .CLUSTER_SIZE(C),
        .NUM_VARIABLES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check("en_b",      64'(bus.en_b),      64'({C{e.wr}}));
        check("we_b",      64'(bus.we_b),      64'({C{e.wr}}));
        check("addr_b",    64'(bus.addr_b),    64'({C{e.addr}}));
        check("din_b",     64'(bus.din_b),     64'({C{e.din}}));
        check("init_busy", 64'(bus.init_busy), 64'(e.busy));
        check("init_done", 64'(bus.init_done), 64'(e.done));
        check("flip_drop", 64'(bus.flip_drop), 64'(e.drop));
        check("dbg_state", 64'(dbg_state),     64'(e.busy));
    endtask

    // ---------------- reference model ----------------
    // Bits written by a sweep: bit 0 of the LFSR, one step per address.
    task automatic model_sweep(input logic [15:0] seed);
        logic [15:0] s;
        exp_t        w;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < N; i++) begin
            w      = '0;
            w.wr   = 1'b1;
            w.addr = W'(i);
            w.din  = s[0];
            w.busy = 1'b1;
            exp_q.push_back(w);
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        w      = '0;
        w.done = 1'b1;
        exp_q.push_back(w);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: checks the current cycle, drives the inputs
    // for the next rising edge, predicts its effect, then advances one cycle.
    task automatic run_cycle(input logic start, input logic [15:0] seed,
                             input logic valid, input logic [W-1:0] addr,
                             input logic value);
        exp_t e;
        exp_t w;
        logic exp_ready;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('0);
        check_outputs(e);
        bus.init_start = start;
        bus.init_seed  = seed;
        bus.flip_valid = valid;
        bus.flip_addr  = addr;
        bus.flip_value = value;
        #1;
        exp_ready = !e.busy && !start;
        check("flip_ready", 64'(bus.flip_ready), 64'(exp_ready));
        if (!e.busy && start) begin
            model_sweep(seed);
        end else if (exp_ready && valid) begin
            w = '0;
            if (int'(addr) < N) begin
                w.wr   = 1'b1;
                w.addr = addr;
                w.din  = value;
            end else begin
                w.drop = 1'b1;
            end
            exp_q.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 16'h0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        logic        r_start;
        logic [15:0] r_seed;
        logic        r_valid;
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.init_start = 1'b0;
        bus.init_seed  = 16'h0;
        bus.flip_valid = 1'b0;
        bus.flip_addr  = '0;
        bus.flip_value = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs(exp_t'('0));
        check("reset_ready", 64'(bus.flip_ready), 64'd1);
        rst = 1'b0;

        // Single flip, then back to an idle bus.
        run_cycle(1'b0, 16'h0, 1'b1, 4'd5, 1'b1);
        idle(2);

        // Back-to-back flips.
        run_cycle(1'b0, 16'h0, 1'b1, 4'd1, 1'b1);
        run_cycle(1'b0, 16'h0, 1'b1, 4'd2, 1'b0);
        run_cycle(1'b0, 16'h0, 1'b1, 4'd3, 1'b1);
        idle(2);

        // Out-of-range flips: exactly N and the top address.
        run_cycle(1'b0, 16'h0, 1'b1, 4'(N), 1'b1);
        idle(1);
        run_cycle(1'b0, 16'h0, 1'b1, 4'd15, 1'b0);
        idle(2);

        // Init sweep with seed 1.
        run_cycle(1'b1, 16'h0001, 1'b0, '0, 1'b0);
        idle(N + 2);

        // init_start and flip_valid together: only the sweep is taken.
        // A request held during the sweep must not be accepted.
        run_cycle(1'b1, 16'h1234, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < N; i++) run_cycle(1'b1, 16'h5555, 1'b1, 4'd6, 1'b1);
        idle(2);

        // Zero seed.
        run_cycle(1'b1, 16'h0000, 1'b0, '0, 1'b0);
        idle(N + 2);

        // Reset while address 3 is being written.
        run_cycle(1'b1, 16'h0BAD, 1'b0, '0, 1'b0);
        idle(3);
        e = exp_q.pop_front();
        check_outputs(e);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_outputs(exp_t'('0));
        @(negedge clk);
        rst = 1'b0;
        idle(N + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r_start = ($urandom_range(0, 19) == 0);
            r_seed  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
            r_valid = ($urandom_range(0, 9) < 7);
            run_cycle(r_start, r_seed, r_valid, W'($urandom_range(0, (1 << W) - 1)),
                      1'($urandom_range(0, 1)));
        end
        idle(N + 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/variable_table_writer.md
VARIABLE_TABLE_WRITER -- requirements
Module: variable_table_writer

Interface
REQ-001 SHALL have parameter VARIABLE_ADDRESS_WIDTH, default 11: address width of each variable table.
REQ-002 SHALL have parameter CLUSTER_SIZE, default 40: number of variable tables driven.
REQ-003 SHALL have parameter NUM_VARIABLES, default 2048: variables in use; legal range 1..2^VARIABLE_ADDRESS_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port init_start  input  1  request random initialisation of all tables.
REQ-007 SHALL have port init_seed  input  16  LFSR seed, sampled when init_start is accepted.
REQ-008 SHALL have port init_busy  output  1  high while an init sweep is issuing writes.
REQ-009 SHALL have port init_done  output  1  one-cycle pulse when a sweep completes.
REQ-010 SHALL have port flip_valid  input  1  flip request valid.
REQ-011 SHALL have port flip_ready  output  1  flip request accepted when valid and ready.
REQ-012 SHALL have port flip_addr  input  VARIABLE_ADDRESS_WIDTH  variable to write.
REQ-013 SHALL have port flip_value  input  1  new value of that variable.
REQ-014 SHALL have port flip_drop  output  1  one-cycle pulse: accepted flip discarded (out-of-range address).
REQ-015 SHALL have ports en_b, we_b  output  CLUSTER_SIZE each  port-B enable/write enable per table.
REQ-016 SHALL have port addr_b  output  VARIABLE_ADDRESS_WIDTH*CLUSTER_SIZE  port-B addresses, table i at bits [i*W +: W].
REQ-017 SHALL have port din_b  output  CLUSTER_SIZE  port-B write data per table.

Function
REQ-018 SHALL implement FSM with states IDLE and INIT; all table-side outputs, init_done, flip_drop registered.
REQ-019 SHALL drive every table identically (broadcast): all en_b/we_b bits equal, all addr_b fields equal, all din_b bits equal.
REQ-020 SHALL assert flip_ready combinationally = (state==IDLE) and not init_start.
REQ-021 SHALL, on flip handshake at edge k with flip_addr < NUM_VARIABLES, drive en_b=we_b=all ones, addr=flip_addr, din=flip_value for exactly the cycle after edge k.
REQ-022 SHALL sustain one accepted flip per cycle; back-to-back handshakes produce back-to-back write cycles.
REQ-023 SHALL, on flip handshake with flip_addr >= NUM_VARIABLES, issue no write and pulse flip_drop in the following cycle.
REQ-024 SHALL, when init_start is high in IDLE, move to INIT at the next edge, loading LFSR with init_seed (seed 16'h0000 replaced by 16'hACE1); init_start has priority over flip_valid.
REQ-025 SHALL, in INIT, issue one broadcast write per cycle to addresses 0,1,...,NUM_VARIABLES-1 in order, din = LFSR bit 0, LFSR advancing one step per write.
REQ-026 SHALL use 16-bit Fibonacci LFSR, taps 16,14,13,11: new bit = b15^b13^b12^b10 shifted into bit 0.
REQ-027 SHALL hold init_busy high during exactly the NUM_VARIABLES write cycles of INIT.
REQ-028 SHALL return to IDLE after the write to NUM_VARIABLES-1 and pulse init_done in that first IDLE cycle.
REQ-029 SHALL ignore init_start while in INIT; flip_ready stays low in INIT.
REQ-030 SHALL drive en_b, we_b, addr_b, din_b all zero in any cycle with no write.

Reset
REQ-031 SHALL, on rst, immediately force state IDLE, all outputs registered zero, LFSR 16'hACE1, address counter 0.
REQ-032 SHALL abort an in-progress sweep on rst without completing it or pulsing init_done; table contents then unspecified.

Verification
REQ-033 SHALL cover: flip_valid=1, addr=5, value=1 in IDLE -> next cycle en_b=we_b=all ones, every addr_b field=5, din_b=all ones; following cycle all zero.
REQ-034 SHALL cover: NUM_VARIABLES=8, init_start, seed 16'h0001 -> init_busy 8 cycles, addresses 0..7 in order, din matching LFSR model, init_done one pulse after.
REQ-035 SHALL cover: init_start and flip_valid same IDLE cycle -> flip_ready=0, flip not accepted, INIT entered.
REQ-036 SHALL cover: flip_addr=NUM_VARIABLES -> no write, flip_drop pulses once.
REQ-037 SHALL cover: rst asserted mid-INIT at address 3 -> outputs zero immediately, no init_done, IDLE with flip_ready=1 after release.
REQ-038 SHALL cover: three consecutive flips (addr 1,2,3) -> three consecutive write cycles, addresses 1,2,3.
